// File: rtl/ram_512x64_arbiter.sv
// ram_512x64_arbiter: two-requester arbiter and sequencer for the 512x64 DFFRAM pair.
// Three-stage flow: accept (A) -> RAM access (B) -> response return (C).
// Optional feature: define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// The default build uses fixed priority, where port 0 always wins.

// Per-port response lane: only the owning port sees the response.
module ram_arb_rsp_lane #(
    parameter logic PORT_ID = 1'b0
) (
    input  logic        c_vld,
    input  logic        c_port,
    input  logic        c_read,
    input  logic [63:0] ram_do,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata
);
    // Reads forward RAM data; write acknowledges carry zero.
    always_comb begin
        rsp_valid = c_vld && (c_port == PORT_ID);
        rsp_rdata = (rsp_valid && c_read) ? ram_do : 64'h0;
    end
endmodule

module ram_512x64_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_we,
    input  logic [8:0]  req0_addr,
    input  logic [63:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_we,
    input  logic [8:0]  req1_addr,
    input  logic [63:0] req1_wdata,
    output logic        rsp0_valid,
    output logic [63:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic [63:0] rsp1_rdata,
    output logic        ram_en,
    output logic [7:0]  ram_we,
    output logic [8:0]  ram_a,
    output logic [63:0] ram_di,
    input  logic [63:0] ram_do
);
    localparam int NUM_PORTS = 2;
    localparam int STAGES    = 2;

    typedef struct packed {
        logic [7:0]  we;
        logic [8:0]  addr;
        logic [63:0] wdata;
    } req_t;

    logic [NUM_PORTS-1:0]        valid;
    logic [NUM_PORTS-1:0]        grant;
    req_t [NUM_PORTS-1:0]        req;
    req_t                        acc_req;
    logic                        acc_vld;
    logic                        acc_port;
    req_t                        b_req;
    logic                        b_port;
    logic                        c_port;
    logic                        c_read;
    logic [STAGES:1]             vld_pipe;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [NUM_PORTS-1:0][63:0]  rsp_rdata;

    assign valid  = {req1_valid, req0_valid};
    assign req[0] = {req0_we, req0_addr, req0_wdata};
    assign req[1] = {req1_we, req1_addr, req1_wdata};

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic ptr;

    // On contention the pointer port wins; a lone requester always wins.
    always_comb begin
        grant = valid;
        if (&valid)
            grant = ptr ? 2'b10 : 2'b01;
        if (RST)
            grant = '0;
    end

    // The pointer hands priority to the port that just lost or was idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ptr <= 1'b0;
        else if (acc_vld)
            ptr <= ~acc_port;
    end
`else
    // Port 0 wins on contention; port 1 is served only when port 0 is idle.
    always_comb begin
        grant = valid;
        if (valid[0])
            grant[1] = 1'b0;
        if (RST)
            grant = '0;
    end
`endif

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign acc_vld    = |grant;
    assign acc_port   = grant[1];
    assign acc_req    = req[acc_port];

    // Stage valids; cleared on reset so in-flight requests get no response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], acc_vld};
    end

    // Stage B holds the accepted request while it is presented to the RAM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            b_req  <= '0;
            b_port <= 1'b0;
        end else if (acc_vld) begin
            b_req  <= acc_req;
            b_port <= acc_port;
        end
    end

    // Stage C remembers the owner and access type while RAM data settles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            c_port <= 1'b0;
            c_read <= 1'b0;
        end else if (vld_pipe[1]) begin
            c_port <= b_port;
            c_read <= (b_req.we == 8'h00);
        end
    end

    // RAM pins sit at zero whenever stage B is empty.
    always_comb begin
        ram_en = vld_pipe[1];
        ram_we = '0;
        ram_a  = '0;
        ram_di = '0;
        if (vld_pipe[1]) begin
            ram_we = b_req.we;
            ram_a  = b_req.addr;
            ram_di = b_req.wdata;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
        ram_arb_rsp_lane #(.PORT_ID(1'(p))) u_lane (
            .c_vld     (vld_pipe[STAGES]),
            .c_port    (c_port),
            .c_read    (c_read),
            .ram_do    (ram_do),
            .rsp_valid (rsp_valid[p]),
            .rsp_rdata (rsp_rdata[p])
        );
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_rdata = rsp_rdata[0];
    assign rsp1_rdata = rsp_rdata[1];
endmodule

// File: tb/tb_ram_512x64_arbiter.sv
// Directed bench for ram_512x64_arbiter with a behavioural DFFRAM model.
// Expectations follow RAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_ram_512x64_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_we, req1_we;
    logic [8:0]  req0_addr, req1_addr;
    logic [63:0] req0_wdata, req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_rdata, rsp1_rdata;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [8:0]  ram_a;
    logic [63:0] ram_di;
    logic [63:0] ram_do = '0;
    logic [63:0] mem [0:511] = '{default: '0};
    int          total = 0;
    int          bad = 0;

    ram_512x64_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
        .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM model: byte-masked write, registered read.
    always @(posedge CLK) begin
        if (ram_en) begin
            logic [63:0] m;
            for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{ram_we[b]}};
            mem[ram_a] <= (mem[ram_a] & ~m) | (ram_di & m);
            ram_do     <= mem[ram_a];
        end
    end

    function automatic logic [63:0] pat(input logic [8:0] a);
        return 64'hA5A5_0000_0000_0000 | {23'h0, a, 23'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v0, input logic [7:0] w0, input logic [8:0] a0, input logic [63:0] d0,
                       input logic v1, input logic [7:0] w1, input logic [8:0] a1, input logic [63:0] d1);
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic idle();
        drv(1'b0, 8'h0, 9'h0, 64'h0, 1'b0, 8'h0, 9'h0, 64'h0);
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [7:0] g0_exp = 8'b0101_0101;
    logic [7:0] g1_exp = 8'b1010_1010;
`else
    logic [7:0] g0_exp = 8'hFF;
    logic [7:0] g1_exp = 8'h00;
`endif

    initial begin
        logic       ep [0:7];
        logic [8:0] ea [0:7];
        int         i0, i1;

        // Reset held with both ports requesting.
        drv(1'b1, 8'h0, 9'h0, 64'h0, 1'b1, 8'h0, 9'h0, 64'h0);
        repeat (2) @(posedge CLK);
        smp();
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_rv0", rsp0_valid, 0);
        chk("rst_rv1", rsp1_valid, 0);
        chk("rst_rd0", rsp0_rdata, 0);
        chk("rst_rd1", rsp1_rdata, 0);
        chk("rst_en", ram_en, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_a", ram_a, 0);
        chk("rst_di", ram_di, 0);

        // Release: port 0 wins the first edge.
        nxt();
        RST = 1'b0;
        smp();
        chk("rel_rdy0", req0_ready, 1);
        chk("rel_rdy1", req1_ready, 0);
        nxt();
        idle();
        smp();
        chk("rel_en", ram_en, 1);
        chk("rel_we", ram_we, 0);
        chk("rel_a", ram_a, 0);
        nxt();
        smp();
        chk("rel_rv0", rsp0_valid, 1);
        chk("rel_rv1", rsp1_valid, 0);
        chk("rel_rd0", rsp0_rdata, 0);
        nxt();

        // Port 1 write then read of the same word on back-to-back cycles.
        drv(1'b0, 8'h0, 9'h0, 64'h0, 1'b1, 8'hFF, 9'h1A5, 64'hDEADBEEF_CAFEF00D);
        smp();
        chk("wr_rdy1", req1_ready, 1);
        chk("wr_rdy0", req0_ready, 0);
        nxt();
        drv(1'b0, 8'h0, 9'h0, 64'h0, 1'b1, 8'h00, 9'h1A5, 64'h0);
        smp();
        chk("wr_en", ram_en, 1);
        chk("wr_we", ram_we, 8'hFF);
        chk("wr_a", ram_a, 9'h1A5);
        chk("wr_di", ram_di, 64'hDEADBEEF_CAFEF00D);
        chk("rd_rdy1", req1_ready, 1);
        nxt();
        idle();
        smp();
        chk("wr_rv1", rsp1_valid, 1);
        chk("wr_rd1", rsp1_rdata, 0);
        chk("wr_rv0", rsp0_valid, 0);
        chk("rd_we", ram_we, 0);
        nxt();
        smp();
        chk("rd_rv1", rsp1_valid, 1);
        chk("rd_rd1", rsp1_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("rd_rd0", rsp0_rdata, 0);
        nxt();

        // Byte-masked write over a zeroed word.
        drv(1'b0, 8'h0, 9'h0, 64'h0, 1'b1, 8'hFF, 9'h010, 64'h0);
        nxt();
        drv(1'b0, 8'h0, 9'h0, 64'h0, 1'b1, 8'h0F, 9'h010, 64'hFFFFFFFF_FFFFFFFF);
        nxt();
        drv(1'b0, 8'h0, 9'h0, 64'h0, 1'b1, 8'h00, 9'h010, 64'h0);
        nxt();
        idle();
        nxt();
        smp();
        chk("mask_rv1", rsp1_valid, 1);
        chk("mask_rd1", rsp1_rdata, 64'h00000000_FFFFFFFF);
        nxt();

        // Preload words for the contention run through port 1.
        for (int i = 0; i < 12; i++) begin
            logic [8:0] a;
            a = (i < 8) ? 9'(9'h100 + i) : 9'(9'h110 + i - 8);
            drv(1'b0, 8'h0, 9'h0, 64'h0, 1'b1, 8'hFF, a, pat(a));
            nxt();
        end
        idle();
        nxt();
        nxt();

        // Both ports stream reads for 8 cycles.
        i0 = 0;
        i1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8)
                drv(1'b1, 8'h0, 9'(9'h100 + i0), 64'h0, 1'b1, 8'h0, 9'(9'h110 + i1), 64'h0);
            else
                idle();
            smp();
            if (i < 8) begin
                chk($sformatf("ct_rdy0_%0d", i), req0_ready, g0_exp[i]);
                chk($sformatf("ct_rdy1_%0d", i), req1_ready, g1_exp[i]);
                ep[i] = ~g0_exp[i];
                ea[i] = g0_exp[i] ? 9'(9'h100 + i0) : 9'(9'h110 + i1);
                if (g0_exp[i]) i0++;
                else i1++;
            end
            if (i >= 2) begin
                chk($sformatf("ct_rv0_%0d", i - 2), rsp0_valid, !ep[i-2]);
                chk($sformatf("ct_rv1_%0d", i - 2), rsp1_valid, ep[i-2]);
                chk($sformatf("ct_rd_%0d", i - 2), ep[i-2] ? rsp1_rdata : rsp0_rdata, pat(ea[i-2]));
            end
            nxt();
        end

        // Reset lands while a read is in stage B.
        drv(1'b1, 8'h0, 9'h105, 64'h0, 1'b0, 8'h0, 9'h0, 64'h0);
        smp();
        chk("mr_rdy0", req0_ready, 1);
        nxt();
        idle();
        RST = 1'b1;
        smp();
        chk("mr_en", ram_en, 0);
        chk("mr_we", ram_we, 0);
        chk("mr_a", ram_a, 0);
        chk("mr_di", ram_di, 0);
        nxt();
        smp();
        chk("mr_rv0", rsp0_valid, 0);
        chk("mr_rv1", rsp1_valid, 0);
        nxt();
        RST = 1'b0;

        // Lone port 1 request right after reset release.
        drv(1'b0, 8'h0, 9'h0, 64'h0, 1'b1, 8'h0, 9'h110, 64'h0);
        smp();
        chk("pr_rdy1", req1_ready, 1);
        nxt();
        idle();
        nxt();
        smp();
        chk("pr_rv1", rsp1_valid, 1);
        chk("pr_rd1", rsp1_rdata, pat(9'h110));
        nxt();
        nxt();

        // Idle: RAM stays disabled.
        for (int i = 0; i < 10; i++) begin
            smp();
            chk($sformatf("idle_en_%0d", i), ram_en, 0);
            chk($sformatf("idle_we_%0d", i), ram_we, 0);
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_512x64_arbiter.md
# ram_512x64_arbiter

Two-requester arbiter and sequencer for the single-ported 512x64 DFFRAM macro pair. It accepts at most one request per cycle from port 0 (typically instruction fetch) or port 1 (typically load/store), drives the RAM enable, byte-write, address and data pins, and returns read data to the originating port with fixed latency. The block sits between the core-side memory interfaces and the RAM macro; it is the only driver of the RAM pins.

## Interface
Parameters:
- none; geometry fixed at 512 words x 64 bits, 8 byte lanes.

Ports:
- CLK  in  1  clock; RAM macro shares this clock
- RST  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present on port N
- req0_ready / req1_ready  out  1  port N accepted this cycle
- req0_we / req1_we  in  8  byte write enables; all-zero means read
- req0_addr / req1_addr  in  9  word address
- req0_wdata / req1_wdata  in  64  write data
- rsp0_valid / rsp1_valid  out  1  response for port N this cycle
- rsp0_rdata / rsp1_rdata  out  64  read data; zero for writes
- ram_en  out  1  to RAM EN
- ram_we  out  8  to RAM WE
- ram_a  out  9  to RAM A
- ram_di  out  64  to RAM Di
- ram_do  in  64  from RAM Do

## Operation
- Stage A (accept): grant logic picks one valid port; reqN_ready = grant to N. Ready depends combinationally on valid; requesters must not gate valid on ready.
- At most one of req0_ready/req1_ready is high per cycle; ready is never high while the port's valid is low.
- Accepted request (we, addr, wdata, port id, is_read = (we == 0)) is registered into stage B.
- Stage B (access): ram_en=1, ram_we/ram_a/ram_di from stage-B register. ram_en=0 and ram_we=0 when stage B is empty.
- Stage C (return): registered flag plus port id; rspN_valid=1 for the owning port only; rspN_rdata = ram_do for reads, 64'h0 for writes; the non-owning port's rdata is 0.
- Writes produce a response (acknowledge) like reads.
- Responses cannot be back-pressured; requesters always sink them.
- Ordering: responses return in acceptance order; a read to an address accepted the cycle after a write to that address returns the new data.
- Priority pointer: 1-bit, reset to port 0. On a grant to port N, pointer moves to the other port (round-robin build only).

## Timing
- Throughput: one request per cycle, sustained, no bubbles.
- Latency: accept in cycle T -> ram_en in T+1 -> rspN_valid in T+2.
- Both valid in the same cycle: grant to pointer port; other port waits; with continuous requests from both, grants alternate 0,1,0,1.
- Single valid: granted immediately regardless of pointer.
- Reset values: req*_ready=0, rsp*_valid=0, rsp*_rdata=0, ram_en=0, ram_we=0, ram_a=0, ram_di=0, pointer=port 0.
- RST asserted mid-operation: stage B and C are cleared asynchronously; in-flight requests are dropped with no response; a write in stage B at the reset edge has undefined effect on RAM contents.
- First accept is possible in the first CLK edge after RST deasserts.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: round-robin pointer as above.
- Not defined: fixed priority, port 0 always wins on contention; pointer register removed; port 1 may starve under continuous port 0 traffic.

## Test plan
- Reset: hold RST with both valids high -> all outputs 0, no ready; release -> port 0 granted on the first edge.
- Single-port write then read: port 1 writes addr 9'h1A5, we=8'hFF, data 64'hDEADBEEF_CAFEF00D at T; reads 9'h1A5 at T+1 -> rsp1_valid at T+2 (rdata 0) and T+3 (rdata 64'hDEADBEEF_CAFEF00D).
- Byte mask: preload 9'h010 with 64'h0; write we=8'h0F, data 64'hFFFFFFFF_FFFFFFFF; read -> 64'h00000000_FFFFFFFF.
- Contention, round-robin build: both ports stream reads for 8 cycles -> grants 0,1,0,1,0,1,0,1; each response reaches the correct port with correct data; without the macro -> port 0 receives all 8 grants, req1_ready stays 0.
- Mid-flight reset: accept read at T, assert RST at T+1 -> no rsp valid at T+2; RAM pins return to 0.
- Idle: no valids for 10 cycles -> ram_en=0, ram_we=0 throughout.
